// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: PC register, one-outstanding-request memory handshake,
// redirect handling with in-flight response discard, and a small {pc, instr} buffer toward decode.
module rv_fetch_unit #(
  parameter int unsigned          XLEN       = 32,
  parameter int unsigned          ILEN       = 32,
  parameter logic [XLEN-1:0]      RESET_PC   = XLEN'(32'h0001_0094),
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            arst_i,
  output logic [XLEN-1:0] instr_addr_o,
  output logic            instr_valid_o,
  input  logic [ILEN-1:0] instr_rdata_i,
  input  logic            instr_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fetch_valid_o,
  output logic [ILEN-1:0] fetch_instr_o,
  output logic [XLEN-1:0] fetch_pc_o,
  input  logic            fetch_ready_i
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_pc_req;
  logic            w_capture;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_after_pop;
  logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [ILEN-1:0] r_fifo_instr [FIFO_DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_fetch_valid;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_redirect_pc     = redirect_pc_i & ~XLEN'(3);
  assign w_fetch_valid     = (r_count != '0);
  assign w_pop             = w_fetch_valid && fetch_ready_i;
  assign w_push            = (r_state == S_REQ) && instr_ready_i && !redirect_i;
  assign w_count_after_pop = r_count - CW'(w_pop);

  assign instr_addr_o  = {2'b00, r_pc_req[XLEN-1:2]};
  assign fetch_valid_o = w_fetch_valid;
  assign fetch_pc_o    = w_fetch_valid ? r_fifo_pc[r_rd_ptr]    : '0;
  assign fetch_instr_o = w_fetch_valid ? r_fifo_instr[r_rd_ptr] : '0;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_pc_req <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_capture) begin
        r_pc_req <= r_pc;
      end
    end
  end

  // r_pc_req holds the address for the whole transaction, so a redirect while
  // waiting (DROP) keeps presenting the stale address until memory answers.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_capture     = 1'b0;
    instr_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect_i) begin
          w_pc_nxt = w_redirect_pc;
        end else if (w_count_after_pop < DEPTH_C) begin
          w_state_nxt = S_REQ;
          w_capture   = 1'b1;
        end
      end
      S_REQ: begin
        instr_valid_o = 1'b1;
        if (instr_ready_i) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = redirect_i ? w_redirect_pc : r_pc + XLEN'(4);
        end else if (redirect_i) begin
          w_state_nxt = S_DROP;
          w_pc_nxt    = w_redirect_pc;
        end
      end
      S_DROP: begin
        instr_valid_o = 1'b1;
        if (redirect_i) begin
          w_pc_nxt = w_redirect_pc;
        end
        if (instr_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_pc_req;
      r_fifo_instr[r_wr_ptr] <= instr_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (arst_i)
    !(w_push && !w_pop && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a transaction-level model of the fetch stage.
module tb_rv_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0001_0094;

  logic        clk = 1'b0;
  logic        arst_i;
  logic [31:0] instr_addr_o;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_i;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_ready_i;

  int n_tests = 0;
  int n_fail  = 0;

  rv_fetch_unit #(
    .XLEN       (32),
    .ILEN       (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .arst_i        (arst_i),
    .instr_addr_o  (instr_addr_o),
    .instr_valid_o (instr_valid_o),
    .instr_rdata_i (instr_rdata_i),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_instr_o (fetch_instr_o),
    .fetch_pc_o    (fetch_pc_o),
    .fetch_ready_i (fetch_ready_i)
  );

  always #5 clk = ~clk;

  // Transaction-level model: one outstanding request, a queue of fetched entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_busy;
  bit          m_stale;

  task automatic model_reset();
    m_q.delete();
    m_pc     = RST_PC;
    m_req_pc = RST_PC;
    m_busy   = 1'b0;
    m_stale  = 1'b0;
  endtask

  task automatic model_step(input bit rd, input logic [31:0] rpc, input bit rdy,
                            input logic [31:0] rdat, input bit frdy);
    if (m_q.size() > 0 && frdy) void'(m_q.pop_front());
    if (m_busy) begin
      if (rdy) begin
        m_busy = 1'b0;
        if (!m_stale && !rd) begin
          m_q.push_back('{pc: m_req_pc, ins: rdat});
          m_pc = m_req_pc + 32'd4;
        end
      end else if (rd) begin
        m_stale = 1'b1;
      end
    end else if (!rd && m_q.size() < DEPTH) begin
      m_busy   = 1'b1;
      m_stale  = 1'b0;
      m_req_pc = m_pc;
    end
    if (rd) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("instr_valid", {31'd0, instr_valid_o}, {31'd0, m_busy});
    if (m_busy) check("instr_addr", instr_addr_o, {2'b00, m_req_pc[31:2]});
    check("fetch_valid", {31'd0, fetch_valid_o}, {31'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      check("fetch_pc", fetch_pc_o, m_q[0].pc);
      check("fetch_instr", fetch_instr_o, m_q[0].ins);
    end
  endtask

  task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy,
                       input logic [31:0] rdat, input bit frdy);
    redirect_i    = rd;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    instr_rdata_i = rdat;
    fetch_ready_i = frdy;
    @(posedge clk);
    model_step(rd, rpc, rdy, rdat, frdy);
    #1;
    compare_all();
  endtask

  initial begin
    int lat;
    bit rd, rdy, frdy;
    logic [31:0] rpc, rdat;

    arst_i = 1'b1;
    redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
    instr_rdata_i = '0; fetch_ready_i = 1'b0;
    model_reset();
    #12;
    check("rst_instr_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_fetch_valid", {31'd0, fetch_valid_o}, 32'd0);
    check("rst_addr", instr_addr_o, 32'h0000_4025);
    check("rst_fetch_pc", fetch_pc_o, 32'd0);
    check("rst_fetch_instr", fetch_instr_o, 32'd0);
    #1 arst_i = 1'b0;

    // First fetch, memory answers after three waiting cycles
    cycle(0, 0, 0, 0, 0);
    check("t1_valid", {31'd0, instr_valid_o}, 32'd1);
    check("t1_addr", instr_addr_o, 32'h0000_4025);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0513, 0);
    check("t1_fpc", fetch_pc_o, 32'h0001_0094);
    check("t1_fins", fetch_instr_o, 32'h0000_0513);
    check("t1_gap", {31'd0, instr_valid_o}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("t1_next_addr", instr_addr_o, 32'h0000_4026);

    // Decode stalled: buffer fills at two entries, fetching stops
    cycle(0, 0, 1, 32'h0010_0093, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("t2_stall", {31'd0, instr_valid_o}, 32'd0);
    check("t2_head", fetch_pc_o, 32'h0001_0094);
    cycle(0, 0, 0, 0, 1);
    check("t2_head2", fetch_pc_o, 32'h0001_0098);
    check("t2_resume", instr_addr_o, 32'h0000_4027);
    cycle(0, 0, 0, 0, 1);
    check("t2_empty", {31'd0, fetch_valid_o}, 32'd0);
    cycle(0, 0, 1, 32'h0000_0013, 0);
    cycle(0, 0, 0, 0, 0);

    // Asynchronous reset pulse between edges while a request is pending
    #1 arst_i = 1'b1;
    #1;
    check("t5_valid", {31'd0, instr_valid_o}, 32'd0);
    check("t5_fvalid", {31'd0, fetch_valid_o}, 32'd0);
    model_reset();
    arst_i = 1'b0;
    cycle(0, 0, 0, 0, 0);
    check("t5_addr", instr_addr_o, 32'h0000_4025);

    // Redirect while waiting: stale address held, response discarded
    cycle(1, 32'h0001_0203, 0, 0, 0);
    check("t3_hold1", instr_addr_o, 32'h0000_4025);
    cycle(0, 0, 0, 0, 0);
    check("t3_hold2", instr_addr_o, 32'h0000_4025);
    cycle(0, 0, 1, 32'hDEAD_BEEF, 0);
    check("t3_drop", {31'd0, fetch_valid_o}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("t3_addr", instr_addr_o, 32'h0000_4080);
    cycle(0, 0, 1, 32'h00A0_0593, 0);
    check("t3_fpc", fetch_pc_o, 32'h0001_0200);
    check("t3_fins", fetch_instr_o, 32'h00A0_0593);

    // Redirect in the same cycle as the response
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'h0002_0008, 1, 32'h1111_1111, 0);
    check("t4_flush", {31'd0, fetch_valid_o}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("t4_addr", instr_addr_o, 32'h0000_8002);

    // PC wrap at the top of the address space
    cycle(1, 32'hFFFF_FFFE, 1, 32'h3333_3333, 0);
    cycle(0, 0, 0, 0, 0);
    check("t6_addr", instr_addr_o, 32'h3FFF_FFFF);
    cycle(0, 0, 1, 32'h2222_2222, 0);
    check("t6_fpc", fetch_pc_o, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 0);
    check("t6_wrap", instr_addr_o, 32'h0000_0000);
    cycle(0, 0, 1, 32'h4444_4444, 1);

    // Randomized traffic
    lat = -1;
    for (int i = 0; i < 4000; i++) begin
      rd   = ($urandom_range(0, 19) == 0);
      rpc  = $urandom;
      frdy = ($urandom_range(0, 9) < 7);
      rdat = $urandom;
      rdy  = 1'b0;
      if (instr_valid_o) begin
        if (lat < 0) lat = int'($urandom_range(0, 3));
        rdy = (lat == 0);
        if (rdy) lat = -1;
        else lat--;
      end
      cycle(rd, rpc, rdy, rdat, frdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of rv_memory_unit's instruction port. It holds the PC and issues word-addressed read requests over the instr valid/ready handshake. Fetched {pc, instruction} pairs go into a small FIFO that feeds decode. It also handles control-flow redirects from execute, including discarding responses that are already in flight.

Parameters:
XLEN, 32, data/address width (from rv_pkg)
ILEN, 32, instruction width (from rv_pkg)
RESET_PC, 32'h0001_0094, byte PC after reset
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
instr_addr_o  out  XLEN  word address to memory = {2'b00, pc[XLEN-1:2]}
instr_valid_o  out  1  read request to memory
instr_rdata_i  in  ILEN  instruction from memory, valid when instr_ready_i=1
instr_ready_i  in  1  memory response strobe
redirect_i  in  1  flush and load new PC (branch/jump taken)
redirect_pc_i  in  XLEN  new byte PC; bits [1:0] ignored (forced 0)
fetch_valid_o  out  1  FIFO head valid toward decode
fetch_instr_o  out  ILEN  FIFO head instruction
fetch_pc_o  out  XLEN  FIFO head byte PC
fetch_ready_i  in  1  decode accepts head this cycle

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=IDLE, FIFO empty, instr_valid_o=0, fetch_valid_o=0, instr_addr_o=RESET_PC>>2. fetch_instr_o/fetch_pc_o=0.
- Memory handshake: once raised, instr_valid_o and instr_addr_o stay stable until instr_ready_i is sampled 1 on a clock edge. instr_valid_o then goes low for at least one cycle before the next request. A request is never aborted.
- States:
  - IDLE: instr_valid_o=0. Go to REQ next cycle if FIFO count < FIFO_DEPTH (count as seen after this cycle's pop) and no redirect is present this cycle. On redirect: pc<=redirect_pc, stay IDLE one cycle.
  - REQ: instr_valid_o=1, address = pc>>2.
    - ready=1, no redirect: push {pc, instr_rdata_i}, pc<=pc+4, go to IDLE.
    - ready=1 with redirect: discard response, pc<=redirect_pc, go to IDLE.
    - ready=0 with redirect: pc_req is held for the address, pc<=redirect_pc, go to DROP.
  - DROP: instr_valid_o=1 with the held stale address. On ready=1, discard the response and go to IDLE. A further redirect in DROP only updates pc.
- Address hold: instr_addr_o comes from a registered request address, captured on IDLE->REQ, so redirects never disturb it mid-transaction.
- FIFO:
  - Push only in REQ on ready without redirect.
  - Pop when fetch_valid_o && fetch_ready_i.
  - Simultaneous push and pop is allowed, including when full.
  - The issue rule guarantees no push into a full FIFO without a same-cycle pop. Overflow is impossible; a simulation assertion flags it.
  - Pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1.
- Redirect flushes the FIFO in the same edge: count<=0 and fetch_valid_o=0 next cycle. A pop in the redirect cycle is still honoured by decode but has no further effect.
- fetch_valid_o = (count != 0). Head outputs are combinational from the FIFO head.
- PC arithmetic: pc+4 wraps modulo 2^XLEN with no fault.
- Latency:
  - Reset deassert -> instr_valid_o=1 after 1 cycle (IDLE->REQ).
  - Memory ready -> fetch_valid_o next cycle.
  - Peak throughput is one instruction per 2 cycles plus the memory wait.

Test Plan:
- Reset release, memory answers 3 cycles after valid with 32'h00000513 -> instr_addr_o=32'h4025 during REQ; fetch_valid_o=1 with fetch_pc_o=32'h10094, fetch_instr_o=32'h00000513; next request addr 32'h4026.
- fetch_ready_i held 0 -> exactly 2 entries (pc 0x10094, 0x10098), then instr_valid_o stays 0. Raise fetch_ready_i -> heads pop in order and fetching resumes at 0x1009C.
- Redirect to 32'h10203 while REQ waiting (ready arrives 2 cycles later with 32'hDEADBEEF) -> address held at 0x4025 until ready; DEADBEEF never appears on fetch; next request addr 32'h4080; fetched pc 0x10200.
- Redirect asserted in the same cycle as instr_ready_i -> response dropped, FIFO empty next cycle, next address = redirect_pc>>2.
- arst_i pulsed mid-REQ (between edges) -> instr_valid_o and fetch_valid_o go 0 immediately. After release, the first address is 32'h4025 again.
- pc=32'hFFFFFFFC fetch (via redirect) -> next pc wraps to 0; request address 0.
